// File: rtl/mopshub_seq_pkg.sv
// rtl/mopshub_seq_pkg.sv - shared types and state encodings for the MOPSHUB test sequencer
package mopshub_seq_pkg;

  // state_dbg encodings, exported so software and benches can decode the state
  localparam logic [2:0] DBG_IDLE        = 3'd0;
  localparam logic [2:0] DBG_WAIT_SIGNON = 3'd1;
  localparam logic [2:0] DBG_RUN_RX      = 3'd2;
  localparam logic [2:0] DBG_GAP         = 3'd3;
  localparam logic [2:0] DBG_RUN_TX      = 3'd4;
  localparam logic [2:0] DBG_RUN_ADV     = 3'd5;
  localparam logic [2:0] DBG_NEXT_BUS    = 3'd6;
  localparam logic [2:0] DBG_DONE        = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE        = DBG_IDLE,
    S_WAIT_SIGNON = DBG_WAIT_SIGNON,
    S_RUN_RX      = DBG_RUN_RX,
    S_GAP         = DBG_GAP,
    S_RUN_TX      = DBG_RUN_TX,
    S_RUN_ADV     = DBG_RUN_ADV,
    S_NEXT_BUS    = DBG_NEXT_BUS,
    S_DONE        = DBG_DONE
  } state_t;

  typedef enum logic [1:0] {
    M_RX_ONLY  = 2'd0,
    M_TX_ONLY  = 2'd1,
    M_RX_TX    = 2'd2,
    M_ADVANCED = 2'd3
  } mode_t;

  // First test phase a bus goes through for a given mode
  function automatic state_t first_phase(input mode_t m);
    case (m)
      M_TX_ONLY:  return S_RUN_TX;
      M_ADVANCED: return S_RUN_ADV;
      default:    return S_RUN_RX;
    endcase
  endfunction

endpackage

// File: rtl/mopshub_next_bus.sv
// rtl/mopshub_next_bus.sv - finds the next / first enabled bus index within a limit
module mopshub_next_bus #(
  parameter int N = 32,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] i_mask,
  input  logic [W-1:0] i_cur,
  input  logic [W-1:0] i_limit,
  input  logic         i_wrap,
  output logic [W-1:0] o_next,
  output logic         o_found,
  output logic [W-1:0] o_first
);

  logic [W-1:0] w_up_idx;
  logic         w_up_found;
  logic         w_first_found;

  // Scan from the top down so the lowest qualifying index is the one left standing
  always_comb begin
    w_up_idx      = '0;
    w_up_found    = 1'b0;
    w_first_found = 1'b0;
    o_first       = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_mask[i] && (W'(i) <= i_limit)) begin
        o_first       = W'(i);
        w_first_found = 1'b1;
        if (W'(i) > i_cur) begin
          w_up_idx   = W'(i);
          w_up_found = 1'b1;
        end
      end
    end
  end

  // With wrap enabled, running off the end falls back to the first enabled bus
  assign o_found = w_up_found | (i_wrap & w_first_found);
  assign o_next  = w_up_found ? w_up_idx : o_first;

endmodule

// File: rtl/mopshub_test_sequencer.sv
// rtl/mopshub_test_sequencer.sv - per-bus RX/TX/advanced test sequencer with timeout supervision
module mopshub_test_sequencer
  import mopshub_seq_pkg::*;
#(
  parameter int N_BUSES = 32,
  parameter int BUS_W   = $clog2(N_BUSES),
  parameter int GAP_CYC = 120,
  parameter int TIMEOUT = 65535,
  parameter int CNT_W   = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [1:0]         i_mode,
  input  logic               i_loop_en,
  input  logic               i_trim_en,
  input  logic [BUS_W-1:0]   i_n_buses,
  input  logic [N_BUSES-1:0] i_bus_mask,
  input  logic               i_end_power_init,
  input  logic               i_sign_on_sig,
  input  logic               i_test_rx_end,
  input  logic               i_test_tx_end,
  input  logic               i_test_advanced_end,
  output logic               o_osc_auto_trim,
  output logic               o_test_rx,
  output logic               o_test_tx,
  output logic               o_test_advanced,
  output logic               o_endwait_all,
  output logic [BUS_W-1:0]   o_bus_sel,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_timeout_err,
  output logic [CNT_W-1:0]   o_pass_cnt,
  output logic [CNT_W-1:0]   o_fail_cnt,
  output logic [2:0]         o_state_dbg
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [BUS_W-1:0] MAX_IDX = BUS_W'(N_BUSES - 1);

  state_t               r_state;
  mode_t                r_mode;
  logic                 r_loop_en;
  logic [BUS_W-1:0]     r_limit;
  logic [N_BUSES-1:0]   r_mask;
  logic [BUS_W-1:0]     r_bus_sel;
  logic [TMR_W-1:0]     r_timer;
  logic [CNT_W-1:0]     r_pass_cnt;
  logic [CNT_W-1:0]     r_fail_cnt;
  logic                 r_osc_auto_trim;
  logic                 r_test_rx;
  logic                 r_test_tx;
  logic                 r_test_adv;
  logic                 r_endwait_all;
  logic                 r_done;
  logic                 r_timeout_err;

  logic [BUS_W-1:0]     w_limit_in;
  logic                 w_idle;
  logic [N_BUSES-1:0]   w_nb_mask;
  logic [BUS_W-1:0]     w_nb_limit;
  logic [BUS_W-1:0]     w_nb_next;
  logic [BUS_W-1:0]     w_nb_first;
  logic                 w_nb_found;
  state_t               w_first_state;
  logic                 w_tmo;
  logic [CNT_W-1:0]     w_pass_inc;
  logic [CNT_W-1:0]     w_fail_inc;

  assign w_limit_in    = (i_n_buses > MAX_IDX) ? MAX_IDX : i_n_buses;
  assign w_idle        = (r_state == S_IDLE);
  assign w_first_state = first_phase(r_mode);
  assign w_tmo         = (r_timer == TMR_W'(TIMEOUT - 1));
  assign w_pass_inc    = (r_pass_cnt == {CNT_W{1'b1}}) ? r_pass_cnt : r_pass_cnt + 1'b1;
  assign w_fail_inc    = (r_fail_cnt == {CNT_W{1'b1}}) ? r_fail_cnt : r_fail_cnt + 1'b1;

  // In IDLE the finder looks at the live inputs so start can pick the first bus;
  // wrap is forced there so found means "any bus enabled"
  assign w_nb_mask  = w_idle ? i_bus_mask : r_mask;
  assign w_nb_limit = w_idle ? w_limit_in : r_limit;

  mopshub_next_bus #(
    .N (N_BUSES),
    .W (BUS_W)
  ) u_next_bus (
    .i_mask  (w_nb_mask),
    .i_cur   (r_bus_sel),
    .i_limit (w_nb_limit),
    .i_wrap  (w_idle | r_loop_en),
    .o_next  (w_nb_next),
    .o_found (w_nb_found),
    .o_first (w_nb_first)
  );

  // Main sequencer FSM with registered strobes, pulses and counters
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= S_IDLE;
      r_mode          <= M_RX_ONLY;
      r_loop_en       <= 1'b0;
      r_limit         <= '0;
      r_mask          <= '0;
      r_bus_sel       <= '0;
      r_timer         <= '0;
      r_pass_cnt      <= '0;
      r_fail_cnt      <= '0;
      r_osc_auto_trim <= 1'b0;
      r_test_rx       <= 1'b0;
      r_test_tx       <= 1'b0;
      r_test_adv      <= 1'b0;
      r_endwait_all   <= 1'b0;
      r_done          <= 1'b0;
      r_timeout_err   <= 1'b0;
    end else begin
      r_endwait_all <= 1'b0;
      r_done        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_timer       <= r_timer + 1'b1;
      if (i_abort && !w_idle) begin
        r_state         <= S_IDLE;
        r_test_rx       <= 1'b0;
        r_test_tx       <= 1'b0;
        r_test_adv      <= 1'b0;
        r_osc_auto_trim <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_start) begin
              r_mode          <= mode_t'(i_mode);
              r_loop_en       <= i_loop_en;
              r_limit         <= w_limit_in;
              r_mask          <= i_bus_mask;
              r_pass_cnt      <= '0;
              r_fail_cnt      <= '0;
              r_osc_auto_trim <= i_trim_en;
              r_bus_sel       <= w_nb_first;
              r_timer         <= '0;
              r_state         <= w_nb_found ? S_WAIT_SIGNON : S_DONE;
            end
          end
          S_WAIT_SIGNON: begin
            if (i_sign_on_sig) begin
              r_state    <= w_first_state;
              r_test_rx  <= (w_first_state == S_RUN_RX);
              r_test_tx  <= (w_first_state == S_RUN_TX);
              r_test_adv <= (w_first_state == S_RUN_ADV);
              r_timer    <= '0;
            end else if (w_tmo) begin
              r_timeout_err <= 1'b1;
              r_fail_cnt    <= w_fail_inc;
              r_state       <= S_DONE;
            end
          end
          S_RUN_RX: begin
            if (i_test_rx_end) begin
              r_test_rx     <= 1'b0;
              r_endwait_all <= 1'b1;
              r_timer       <= '0;
              if (r_mode == M_RX_TX) begin
                r_state <= S_GAP;
              end else begin
                r_pass_cnt <= w_pass_inc;
                r_state    <= S_NEXT_BUS;
              end
            end else if (w_tmo) begin
              r_test_rx     <= 1'b0;
              r_timeout_err <= 1'b1;
              r_fail_cnt    <= w_fail_inc;
              r_state       <= S_NEXT_BUS;
            end
          end
          S_GAP: begin
            if (r_timer == TMR_W'(GAP_CYC - 1)) begin
              r_test_tx <= 1'b1;
              r_timer   <= '0;
              r_state   <= S_RUN_TX;
            end
          end
          S_RUN_TX: begin
            if (i_test_tx_end) begin
              r_test_tx  <= 1'b0;
              r_pass_cnt <= w_pass_inc;
              r_state    <= S_NEXT_BUS;
            end else if (w_tmo) begin
              r_test_tx     <= 1'b0;
              r_timeout_err <= 1'b1;
              r_fail_cnt    <= w_fail_inc;
              r_state       <= S_NEXT_BUS;
            end
          end
          S_RUN_ADV: begin
            if (i_test_advanced_end) begin
              r_test_adv <= 1'b0;
              r_pass_cnt <= w_pass_inc;
              r_state    <= S_NEXT_BUS;
            end else if (w_tmo) begin
              r_test_adv    <= 1'b0;
              r_timeout_err <= 1'b1;
              r_fail_cnt    <= w_fail_inc;
              r_state       <= S_NEXT_BUS;
            end
          end
          S_NEXT_BUS: begin
            if (w_nb_found) begin
              r_bus_sel  <= w_nb_next;
              r_state    <= w_first_state;
              r_test_rx  <= (w_first_state == S_RUN_RX);
              r_test_tx  <= (w_first_state == S_RUN_TX);
              r_test_adv <= (w_first_state == S_RUN_ADV);
              r_timer    <= '0;
            end else begin
              r_state <= S_DONE;
            end
          end
          S_DONE: begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        endcase
      end
      // Power-init completion ends the trim request regardless of state
      if (i_end_power_init) begin
        r_osc_auto_trim <= 1'b0;
      end
    end
  end

  assign o_osc_auto_trim = r_osc_auto_trim;
  assign o_test_rx       = r_test_rx;
  assign o_test_tx       = r_test_tx;
  assign o_test_advanced = r_test_adv;
  assign o_endwait_all   = r_endwait_all;
  assign o_bus_sel       = r_bus_sel;
  assign o_busy          = !w_idle;
  assign o_done          = r_done;
  assign o_timeout_err   = r_timeout_err;
  assign o_pass_cnt      = r_pass_cnt;
  assign o_fail_cnt      = r_fail_cnt;
  assign o_state_dbg     = r_state;

endmodule

// File: tb/tb_mopshub_test_sequencer.sv
// tb/tb_mopshub_test_sequencer.sv - directed self-checking bench for the MOPSHUB test sequencer
module tb_mopshub_test_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        loop_en = 1'b0;
  logic        trim_en = 1'b0;
  logic [4:0]  n_buses = 5'd0;
  logic [31:0] bus_mask = 32'd0;
  logic        end_power_init = 1'b0;
  logic        sign_on_sig = 1'b0;
  logic        rx_end = 1'b0;
  logic        tx_end = 1'b0;
  logic        adv_end = 1'b0;

  logic        osc_auto_trim, test_rx, test_tx, test_adv, endwait_all, busy, done, timeout_err;
  logic [4:0]  bus_sel;
  logic [15:0] pass_cnt, fail_cnt;
  logic [2:0]  state_dbg;

  int n_assert = 0;
  int n_fail = 0;

  mopshub_test_sequencer #(
    .N_BUSES (32),
    .BUS_W   (5),
    .GAP_CYC (120),
    .TIMEOUT (65535),
    .CNT_W   (16)
  ) dut (
    .i_clk               (clk),
    .i_rst_n             (rst_n),
    .i_start             (start),
    .i_abort             (abort),
    .i_mode              (mode),
    .i_loop_en           (loop_en),
    .i_trim_en           (trim_en),
    .i_n_buses           (n_buses),
    .i_bus_mask          (bus_mask),
    .i_end_power_init    (end_power_init),
    .i_sign_on_sig       (sign_on_sig),
    .i_test_rx_end       (rx_end),
    .i_test_tx_end       (tx_end),
    .i_test_advanced_end (adv_end),
    .o_osc_auto_trim     (osc_auto_trim),
    .o_test_rx           (test_rx),
    .o_test_tx           (test_tx),
    .o_test_advanced     (test_adv),
    .o_endwait_all       (endwait_all),
    .o_bus_sel           (bus_sel),
    .o_busy              (busy),
    .o_done              (done),
    .o_timeout_err       (timeout_err),
    .o_pass_cnt          (pass_cnt),
    .o_fail_cnt          (fail_cnt),
    .o_state_dbg         (state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #960000;
    $display("FAIL watchdog observed=expired expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic pick(input int w);
    case (w)
      0:       return test_rx;
      1:       return test_tx;
      2:       return test_adv;
      default: return done;
    endcase
  endfunction

  task automatic wait_hi(input int w, input int max, input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (pick(w)) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk(tag, {31'd0, ok}, 32'd1);
  endtask

  task automatic start_run(input logic [1:0] m, input logic lp, input logic tr,
                           input logic [4:0] n, input logic [31:0] mk);
    mode = m; loop_en = lp; trim_en = tr; n_buses = n; bus_mask = mk;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_end(input int w);
    rx_end = (w == 0); tx_end = (w == 1); adv_end = (w == 2);
    tick();
    rx_end = 1'b0; tx_end = 1'b0; adv_end = 1'b0;
  endtask

  initial begin
    int k;
    logic seen;

    // Reset state
    tick(); tick();
    chk("reset_outputs", {16'd0, osc_auto_trim, test_rx, test_tx, test_adv, endwait_all, busy, done,
                          timeout_err, bus_sel, state_dbg}, 32'd0);
    chk("reset_counters", {pass_cnt, fail_cnt}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_state", {29'd0, state_dbg}, 32'd0);

    // RX_ONLY over buses 0 and 4
    sign_on_sig = 1'b1;
    start_run(2'd0, 1'b0, 1'b0, 5'd15, 32'h0000_0011);
    chk("t1_wait_signon", {28'd0, busy, state_dbg}, 32'h9);
    chk("t1_first_bus", {27'd0, bus_sel}, 32'd0);
    for (int b = 0; b < 2; b++) begin
      wait_hi(0, 5, "t1_rx_start");
      chk("t1_rx_bus", {27'd0, bus_sel}, (b == 0) ? 32'd0 : 32'd4);
      repeat (50) tick();
      pulse_end(0);
      chk("t1_endwait_hi", {30'd0, endwait_all, test_rx}, 32'h2);
      tick();
      chk("t1_endwait_lo", {31'd0, endwait_all}, 32'd0);
    end
    wait_hi(3, 5, "t1_done");
    chk("t1_counts", {pass_cnt, fail_cnt}, {16'd2, 16'd0});
    tick();
    chk("t1_done_pulse", {30'd0, done, busy}, 32'd0);

    // RX_TX on bus 3 with the inter-phase gap; a stray TX end in the gap is ignored
    start_run(2'd2, 1'b0, 1'b0, 5'd31, 32'h0000_0008);
    chk("t2_bus", {27'd0, bus_sel}, 32'd3);
    wait_hi(0, 5, "t2_rx_start");
    repeat (10) tick();
    pulse_end(0);
    chk("t2_gap_state", {28'd0, endwait_all, state_dbg}, 32'hB);
    k = 0;
    while (!test_tx && k < 200) begin
      tx_end = (k == 5);
      tick();
      k++;
    end
    tx_end = 1'b0;
    chk("t2_gap_len", k, 32'd120);
    repeat (5) tick();
    pulse_end(1);
    chk("t2_tx_drop", {31'd0, test_tx}, 32'd0);
    wait_hi(3, 5, "t2_done");
    chk("t2_counts", {pass_cnt, fail_cnt}, {16'd1, 16'd0});

    // ADVANCED over buses 0..5, bus 2 never finishes
    start_run(2'd3, 1'b0, 1'b0, 5'd5, 32'hFFFF_FFFF);
    for (int b = 0; b < 6; b++) begin
      wait_hi(2, 5, "t3_adv_start");
      chk("t3_bus", {27'd0, bus_sel}, b);
      if (b == 2) begin
        k = 0;
        while (test_adv && k < 70000) begin
          tick();
          k++;
        end
        chk("t3_timeout_len", k, 32'd65535);
        chk("t3_timeout_err", {31'd0, timeout_err}, 32'd1);
        tick();
        chk("t3_timeout_pulse", {31'd0, timeout_err}, 32'd0);
      end else begin
        repeat (20) tick();
        pulse_end(2);
        chk("t3_adv_drop", {30'd0, test_adv, timeout_err}, 32'd0);
      end
    end
    wait_hi(3, 5, "t3_done");
    chk("t3_counts", {pass_cnt, fail_cnt}, {16'd5, 16'd1});

    // Looping TX_ONLY over buses 0,1; start while busy ignored; abort mid-TX
    start_run(2'd1, 1'b1, 1'b0, 5'd31, 32'h0000_0003);
    for (int i = 0; i < 4; i++) begin
      wait_hi(1, 5, "t4_tx_start");
      chk("t4_bus", {27'd0, bus_sel}, i % 2);
      if (i == 0) begin
        mode = 2'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t4_busy_start", {28'd0, test_tx, state_dbg}, 32'hC);
      end
      repeat (3) tick();
      pulse_end(1);
    end
    wait_hi(1, 5, "t4_tx_start5");
    chk("t4_bus5", {27'd0, bus_sel}, 32'd0);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_abort", {27'd0, test_rx, test_tx, test_adv, busy, state_dbg}, 32'd0);
    chk("t4_hold_counts", {pass_cnt, fail_cnt}, {16'd4, 16'd0});
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      seen = seen | done;
      tick();
    end
    chk("t4_no_done", {31'd0, seen}, 32'd0);

    // Oscillator trim request held until the cycle after end_power_init
    sign_on_sig = 1'b0;
    start_run(2'd0, 1'b0, 1'b1, 5'd0, 32'h0000_0001);
    chk("t5_trim_on", {28'd0, osc_auto_trim, state_dbg}, 32'h9);
    repeat (3) tick();
    chk("t5_trim_hold", {28'd0, osc_auto_trim, state_dbg}, 32'h9);
    end_power_init = 1'b1;
    tick();
    end_power_init = 1'b0;
    chk("t5_trim_off", {31'd0, osc_auto_trim}, 32'd0);
    sign_on_sig = 1'b1;
    wait_hi(0, 5, "t5_rx_start");
    pulse_end(0);
    wait_hi(3, 5, "t5_done");
    chk("t5_counts", {pass_cnt, fail_cnt}, {16'd1, 16'd0});

    // No enabled bus: DONE immediately, done two cycles after start
    start_run(2'd0, 1'b0, 1'b0, 5'd31, 32'h0000_0000);
    chk("t6_done_state", {26'd0, test_rx, test_tx, test_adv, done, state_dbg[1:0]}, 32'h3);
    chk("t6_state", {29'd0, state_dbg}, 32'd7);
    tick();
    chk("t6_done_pulse", {26'd0, test_rx, test_tx, test_adv, done, busy, osc_auto_trim}, 32'h4);
    chk("t6_counts", {pass_cnt, fail_cnt}, 32'd0);

    // Asynchronous reset while bus 1 is in RUN_RX
    start_run(2'd0, 1'b0, 1'b0, 5'd31, 32'h0000_0003);
    wait_hi(0, 5, "t7_rx0");
    pulse_end(0);
    wait_hi(0, 5, "t7_rx1");
    chk("t7_pre_reset", {pass_cnt, 11'd0, bus_sel}, {16'd1, 16'd1});
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_reset_outputs", {16'd0, osc_auto_trim, test_rx, test_tx, test_adv, endwait_all, busy, done,
                             timeout_err, bus_sel, state_dbg}, 32'd0);
    chk("t7_reset_counters", {pass_cnt, fail_cnt}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t7_idle_after", {28'd0, busy, state_dbg}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mopshub_test_sequencer.md
Name: mopshub_test_sequencer

Overview:
Synthesisable, parametrised sequencer for MOPSHUB system-level bring-up and soak testing.
- Power-up path: optionally requests oscillator trimming, then waits for sign-on.
- Per-bus loop: walks every enabled CAN bus up to n_buses and drives the data generator's test_rx / test_tx / test_advanced strobes for each one.
- Supervision: times out a test phase that does not finish and counts pass/fail per bus.
- Generalises the fixed 16-bus, single-mode test flow to N buses, four modes, bus masking, looping and timeout supervision.

Parameters:
- N_BUSES, 32, number of bus slots (2..32).
- BUS_W, $clog2(N_BUSES), bus index width.
- GAP_CYC, 120, clk cycles between RX end and TX start in mode RX_TX (3 us at 40 MHz).
- TIMEOUT, 65535, max clk cycles per phase (includes WAIT_SIGNON) before declaring failure.
- CNT_W, 16, width of the pass/fail counters.

Ports:
- clk  in  1  system clock (40 MHz).
- rst  in  1  asynchronous active-low reset.
- start  in  1  1-cycle pulse; accepted only in IDLE.
- abort  in  1  level; forces return to IDLE.
- mode  in  2  0=RX_ONLY, 1=TX_ONLY, 2=RX_TX, 3=ADVANCED; latched at start.
- loop_en  in  1  restart from the first enabled bus after the last one; latched at start.
- trim_en  in  1  request oscillator auto-trim at start; latched at start.
- n_buses  in  BUS_W  highest bus index to test; latched at start.
- bus_mask  in  N_BUSES  1 = bus enabled; latched at start.
- end_power_init  in  1  power-init-done flag from the hub.
- sign_on_sig  in  1  hub sign-on flag.
- test_rx_end, test_tx_end, test_advanced_end  in  1 each  phase-complete pulses from the generator.
- osc_auto_trim  out  1  trim request level.
- test_rx, test_tx, test_advanced  out  1 each  phase strobes (levels).
- endwait_all  out  1  1-cycle pulse after each RX phase ends.
- bus_sel  out  BUS_W  bus under test.
- busy  out  1  high in every state except IDLE.
- done  out  1  1-cycle pulse when a non-looping run completes.
- timeout_err  out  1  1-cycle pulse on phase timeout.
- pass_cnt, fail_cnt  out  CNT_W each  buses passed / failed.
- state_dbg  out  3  current state encoding.

Behaviour:
- Reset: all outputs 0, state IDLE; takes effect asynchronously, including mid-run.
- States: IDLE, WAIT_SIGNON, RUN_RX, GAP, RUN_TX, RUN_ADV, NEXT_BUS, DONE.
- IDLE + start:
  - latch mode, loop_en, trim_en, n_buses, bus_mask;
  - clear pass_cnt and fail_cnt;
  - osc_auto_trim <= trim_en;
  - bus_sel <= first enabled index <= n_buses;
  - go to WAIT_SIGNON. busy is high the next cycle.
- osc_auto_trim clears in the cycle after end_power_init=1, in any state.
- No enabled bus <= n_buses: start goes straight to DONE. No strobes are raised and the counters stay 0.
- WAIT_SIGNON: on sign_on_sig=1, enter the first phase of the mode on the next cycle:
  - RX_ONLY and RX_TX go to RUN_RX;
  - TX_ONLY goes to RUN_TX;
  - ADVANCED goes to RUN_ADV.
  - The phase strobe is high in the same cycle the state is entered.
- RUN_RX: test_rx=1 until test_rx_end. Then, on the next cycle:
  - test_rx=0 and endwait_all=1 for exactly one cycle;
  - RX_TX goes to GAP; RX_ONLY goes to NEXT_BUS.
- GAP: counts GAP_CYC cycles, then RUN_TX.
- RUN_TX / RUN_ADV: strobe high until the matching end pulse, then NEXT_BUS.
- Phase timer: resets on every phase entry. If the end pulse has not arrived after TIMEOUT cycles:
  - drop the strobe, pulse timeout_err, increment fail_cnt;
  - go to NEXT_BUS (WAIT_SIGNON timeout goes to DONE).
- End pulse and timeout in the same cycle: end wins (pass).
- Pass: pass_cnt increments once per bus that completes all phases of its mode.
- Counters saturate at 2^CNT_W-1; no wrap.
- NEXT_BUS (1 cycle): bus_sel <= next enabled index > bus_sel and <= n_buses.
  - If none and loop_en: wrap to the first enabled index.
  - If none and not loop_en: go to DONE.
  - Then enter the first phase again. WAIT_SIGNON is not repeated.
- DONE: pulse done for 1 cycle, then IDLE.
- Ignored inputs:
  - Stray end pulses outside their phase.
  - start while busy.
- abort (any non-IDLE state): IDLE next cycle.
  - All strobes and osc_auto_trim go 0.
  - No done pulse; counters hold their values.
- n_buses > N_BUSES-1 is clamped to N_BUSES-1.

Decomposition:
- Package mopshub_seq_pkg: state_t enum, mode_t enum (RX_ONLY, TX_ONLY, RX_TX, ADVANCED), state_dbg encoding constants.
- Sub-module mopshub_next_bus: combinational finder.
  - Inputs: mask, current index, limit, wrap.
  - Outputs: next index, found flag, first index.

Test Plan:
- mode=RX_ONLY, bus_mask=32'h0000_0011, n_buses=15, end pulses after 50 cycles:
  - test_rx visits bus_sel 0 then 4;
  - endwait_all pulses twice;
  - pass_cnt=2, done pulse, fail_cnt=0.
- mode=RX_TX, single bus 3:
  - test_tx rises exactly GAP_CYC cycles after the endwait_all pulse;
  - pass_cnt=1.
- mode=ADVANCED, bus_mask all ones, n_buses=5, bus 2 never ends:
  - timeout_err once after 65535 cycles;
  - fail_cnt=1, pass_cnt=5.
- loop_en=1, mask 32'h3: bus_sel sequence 0,1,0,1; then abort mid-RUN_TX:
  - strobes 0 next cycle, state IDLE, no done pulse.
- trim_en=1: osc_auto_trim high from start until the cycle after end_power_init.
- start with bus_mask=0: done 2 cycles later, no strobes raised.
- rst asserted during RUN_RX: all outputs 0 immediately.
